// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver. Oversamples the line at CLKS_PER_BIT clocks
// per bit, qualifies the start bit at its midpoint, shifts data in LSB first,
// checks the stop bit, and offers the byte on a valid/ack handshake.
// Every flop is clocked on the falling edge of clk.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ser_in,
  input  logic       dout_ack,
  output logic [7:0] dout_byte,
  output logic       dout_valid,
  output logic       frame_err,
  output logic       overrun_err,
  output logic       rx_busy
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [CW-1:0] LAST    = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP, S_BREAK
  } state_t;

  logic [1:0]    sync_q;
  logic          rx_s;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [7:0]    byte_q, byte_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          ovr_q, ovr_d;
  logic          busy_q, busy_d;

  // Two-flop synchronizer; resets to the idle (high) line level so a reset
  // release never looks like a start edge.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], ser_in};
  end

  assign rx_s = sync_q[1];

  // State and datapath registers.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      byte_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic. The cycle IDLE sees rx_s low is T0; the start bit is
  // checked at T0+HALF, data bit i at T0+HALF+(i+1)*CLKS_PER_BIT and the stop
  // bit at T0+HALF+9*CLKS_PER_BIT. A good stop bit returns straight to IDLE
  // so a following start bit with no idle gap is still caught.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    byte_d  = byte_q;
    valid_d = valid_q & ~dout_ack;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (!rx_s) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s ? S_IDLE : S_DATA;  // high at midpoint = glitch
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          shreg_d = {rx_s, shreg_q[7:1]};
          if (bit_q == 3'd7) state_d = S_STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            byte_d  = shreg_q;
            valid_d = 1'b1;
            // An ack landing on the load cycle consumes the old byte.
            ovr_d   = valid_q & ~dout_ack;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_BREAK: begin
        // Hold here while the line is low so a break gives one frame_err.
        if (rx_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  assign dout_byte   = byte_q;
  assign dout_valid  = valid_q;
  assign frame_err   = ferr_q;
  assign overrun_err = ovr_q;
  assign rx_busy     = busy_q;

endmodule
